div_unit: RTL

Multicycle signed 32-bit divider for the multicycle CPU datapath. It is the responder on the same start/done handshake the datapath uses for the multiplier. The control unit pulses div_control with operands held in the A and B registers. The block iterates internally, then returns the quotient on lo and the remainder on hi, and pulses div_end. A zero divisor is reported on div_zero so the control unit can take the divide-by-zero exception (vector 255).

---
 rtl/div_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: magnitudes are divided MSB-first, one
// quotient bit per clock, and the signs are re-applied in a final cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             div_control,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_end,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             q_neg_q, r_neg_q;
  logic             div_end_q, div_zero_q, busy_q;

  logic [WIDTH:0]   shifted_s, diff_s;
  logic [WIDTH-1:0] rem_d, dvd_d, a_mag_d, b_mag_d, lo_d, hi_d;

  // One restoring step; the dividend register fills with quotient bits as it drains.
  always_comb begin
    shifted_s = {rem_q, dvd_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    rem_d     = shifted_s[WIDTH-1:0];
    dvd_d     = {dvd_q[WIDTH-2:0], 1'b0};
    if (!diff_s[WIDTH]) begin
      rem_d = diff_s[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted_s[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
    end
    if (a[WIDTH-1]) begin
      a_mag_d = -a;
    end else begin
      a_mag_d = a;
    end
    if (b[WIDTH-1]) begin
      b_mag_d = -b;
    end else begin
      b_mag_d = b;
    end
    if (q_neg_q) begin
      lo_d = -dvd_q;
    end else begin
      lo_d = dvd_q;
    end
    if (r_neg_q) begin
      hi_d = -rem_q;
    end else begin
      hi_d = rem_q;
    end
  end

  // Control FSM with registered results and handshake pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_end_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      div_end_q  <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_control) begin
            if (b == '0) begin
              div_zero_q <= 1'b1;
              div_end_q  <= 1'b1;
            end else begin
              dvd_q   <= a_mag_d;
              dvs_q   <= b_mag_d;
              q_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              r_neg_q <= a[WIDTH-1];
              rem_q   <= '0;
              count_q <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          dvd_q   <= dvd_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          lo_q      <= lo_d;
          hi_q      <= hi_d;
          div_end_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_end  = div_end_q;
  assign div_zero = div_zero_q;
  assign busy     = busy_q;

endmodule
